// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM arbiter.
//   state_e : arbiter FSM states
//   owner_e : which requester owns the current access
package sram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD       = 2'd1,
    WR_SETUP = 2'd2,
    WR_PULSE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the CPU/host requesters, the arbiter and the SRAM pins.
//   slave  : arbiter side (requests and sram_din in; grants, done, rdata, strobes out)
//   master : system side (drives requests and sram_din; observes the rest)
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = sram_arb_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = sram_arb_pkg::DEF_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_done;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_adr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_done;

  logic [DATA_W-1:0] rdata;

  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [ADDR_W-1:0] sram_adr;
  logic [DATA_W-1:0] sram_dout;
  logic              sram_dout_en;
  logic [DATA_W-1:0] sram_din;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
    input  host_req, host_we, host_adr, host_wdata,
    input  sram_din,
    output cpu_stall, cpu_done, host_gnt, host_done, rdata,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_adr, sram_dout, sram_dout_en
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata,
    output host_req, host_we, host_adr, host_wdata,
    output sram_din,
    input  cpu_stall, cpu_done, host_gnt, host_done, rdata,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_adr, sram_dout, sram_dout_en
  );

endinterface

// File: rtl/sram_arb_sel.sv
// Priority select with host-burst limiter.
//   clk, reset     : clock, synchronous active-high reset
//   arb_en         : arbiter is in a cycle that may accept a request
//   cpu_req        : CPU request
//   host_req       : host request
//   grant_c        : an access is accepted this cycle
//   owner_c        : winner of this cycle's arbitration
module sram_arb_sel
  import sram_arb_pkg::*;
#(
  parameter int unsigned HOST_BURST_MAX = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   arb_en,
  input  logic   cpu_req,
  input  logic   host_req,
  output logic   grant_c,
  output owner_e owner_c
);

  localparam int unsigned STREAK_W = (HOST_BURST_MAX < 1) ? 1 : $clog2(HOST_BURST_MAX + 1);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                burst_full;
  logic                cpu_win;

  // Host wins by default; a full host burst hands the next slot to a waiting CPU.
  always_comb begin
    burst_full = (streak_q == STREAK_W'(HOST_BURST_MAX));
    cpu_win    = cpu_req & (~host_req | burst_full);
    grant_c    = arb_en & (cpu_req | host_req);
    owner_c    = cpu_win ? OWN_CPU : OWN_HOST;
  end

  // Streak counts host grants that made the CPU wait.
  always_comb begin
    streak_d = streak_q;
    if (grant_c) begin
      if (!cpu_req || cpu_win) begin
        streak_d = '0;
      end else if (!burst_full) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester (CPU, host) arbiter for an asynchronous SRAM.
//   clk, reset : board clock, synchronous active-high reset
//   bus        : request/response signals for CPU and host plus SRAM pins
// Reads take RD for one cycle; writes take WR_SETUP then WR_PULSE.
// Done pulses land in the following IDLE cycle, which also arbitrates.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned HOST_BURST_MAX = 4
) (
  input  logic           clk,
  input  logic           reset,
  sram_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  owner_e            own_q, own_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dout_en_q, dout_en_d;
  logic              cpu_done_q, cpu_done_d;
  logic              host_done_q, host_done_d;
  logic              host_gnt_c;
  logic              pick_host;
  logic              pick_we;

  logic              sel_grant_c;
  owner_e            sel_owner_c;

  sram_arb_sel #(
    .HOST_BURST_MAX (HOST_BURST_MAX)
  ) u_sel (
    .clk      (clk),
    .reset    (reset),
    .arb_en   ((state_q == IDLE) && !reset),
    .cpu_req  (bus.cpu_req),
    .host_req (bus.host_req),
    .grant_c  (sel_grant_c),
    .owner_c  (sel_owner_c)
  );

  // Next state and next strobe values; strobes are registered from these.
  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    adr_d       = adr_q;
    dout_d      = dout_q;
    rdata_d     = rdata_q;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    dout_en_d   = 1'b0;
    cpu_done_d  = 1'b0;
    host_done_d = 1'b0;
    host_gnt_c  = 1'b0;
    pick_host   = (sel_owner_c == OWN_HOST);
    pick_we     = pick_host ? bus.host_we : bus.cpu_we;

    case (state_q)
      IDLE: begin
        if (sel_grant_c) begin
          own_d      = sel_owner_c;
          host_gnt_c = pick_host;
          adr_d      = pick_host ? bus.host_adr : bus.cpu_adr;
          dout_d     = pick_host ? bus.host_wdata : bus.cpu_wdata;
          ce_n_d     = 1'b0;
          if (pick_we) begin
            state_d   = WR_SETUP;
            dout_en_d = 1'b1;
          end else begin
            state_d   = RD;
            oe_n_d    = 1'b0;
          end
        end
      end
      RD: begin
        state_d     = IDLE;
        rdata_d     = bus.sram_din;
        cpu_done_d  = (own_q == OWN_CPU);
        host_done_d = (own_q == OWN_HOST);
      end
      WR_SETUP: begin
        state_d   = WR_PULSE;
        ce_n_d    = 1'b0;
        we_n_d    = 1'b0;
        dout_en_d = 1'b1;
      end
      WR_PULSE: begin
        state_d     = IDLE;
        cpu_done_d  = (own_q == OWN_CPU);
        host_done_d = (own_q == OWN_HOST);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      own_q       <= OWN_CPU;
      adr_q       <= '0;
      dout_q      <= '0;
      rdata_q     <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dout_en_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      host_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      adr_q       <= adr_d;
      dout_q      <= dout_d;
      rdata_q     <= rdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dout_en_q   <= dout_en_d;
      cpu_done_q  <= cpu_done_d;
      host_done_q <= host_done_d;
    end
  end

  assign bus.sram_ce_n    = ce_n_q;
  assign bus.sram_oe_n    = oe_n_q;
  assign bus.sram_we_n    = we_n_q;
  assign bus.sram_adr     = adr_q;
  assign bus.sram_dout    = dout_q;
  assign bus.sram_dout_en = dout_en_q;
  assign bus.rdata        = rdata_q;
  assign bus.cpu_done     = cpu_done_q;
  assign bus.host_done    = host_done_q;
  assign bus.host_gnt     = host_gnt_c;
  // Stall drops in the done cycle so the CPU can release its request in time.
  assign bus.cpu_stall    = bus.cpu_req & ~cpu_done_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an SRAM model and a completion scoreboard.
module tb_sram_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  typedef struct packed {
    logic          host;
    logic          rd;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  logic [DW-1:0] mem [256];
  bit            mem_init = 1'b0;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .HOST_BURST_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: reads while ce/oe low, write lands when the pulse ends.
  assign bus.sram_din = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_adr] : 16'h0000;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[5]   <= 16'h002D;
      mem_init <= 1'b1;
    end else if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dout_en) begin
      mem[bus.sram_adr] <= bus.sram_dout;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t mk(input logic host, input logic rd, input logic [DW-1:0] data);
    exp_t e;
    e.host = host;
    e.rd   = rd;
    e.data = data;
    return e;
  endfunction

  // Bus-level safety checks every cycle, plus completion scoreboard.
  always @(negedge clk) begin
    exp_t e;
    check("no_oe_we_overlap", 32'(!(!bus.sram_oe_n && !bus.sram_we_n)), 1);
    check("no_dout_en_with_oe", 32'(!(bus.sram_dout_en && !bus.sram_oe_n)), 1);
    if (bus.cpu_done || bus.host_done) begin
      check("single_done", 32'(bus.cpu_done & bus.host_done), 0);
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_owner", 32'(bus.host_done), 32'(e.host));
        if (e.rd) check("sb_rdata", 32'(bus.rdata), 32'(e.data));
      end
    end
  end

  initial begin
    int dones;
    int cyc;
    reset = 1'b1;
    bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0;  bus.cpu_adr = '0;  bus.cpu_wdata = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_adr = '0; bus.host_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ce_n", 32'(bus.sram_ce_n), 1);
    check("rst_oe_n", 32'(bus.sram_oe_n), 1);
    check("rst_we_n", 32'(bus.sram_we_n), 1);
    check("rst_dout_en", 32'(bus.sram_dout_en), 0);
    check("rst_adr", 32'(bus.sram_adr), 0);
    check("rst_dout", 32'(bus.sram_dout), 0);
    check("rst_rdata", 32'(bus.rdata), 0);
    check("rst_dones", 32'({bus.cpu_done, bus.host_done, bus.host_gnt}), 0);
    reset = 1'b0;
    @(negedge clk);

    // CPU read of 0x05
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 8'h05;
    sb.push_back(mk(1'b0, 1'b1, 16'h002D));
    #1;
    check("t1_c0_stall", 32'(bus.cpu_stall), 1);
    check("t1_c0_ce_n", 32'(bus.sram_ce_n), 1);
    check("t1_c0_gnt", 32'(bus.host_gnt), 0);
    @(negedge clk);
    check("t1_c1_strobes", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dout_en}), 32'b0010);
    check("t1_c1_adr", 32'(bus.sram_adr), 32'h05);
    check("t1_c1_stall", 32'(bus.cpu_stall), 1);
    check("t1_c1_done", 32'(bus.cpu_done), 0);
    @(negedge clk);
    check("t1_c2_done", 32'(bus.cpu_done), 1);
    check("t1_c2_rdata", 32'(bus.rdata), 32'h002D);
    check("t1_c2_stall", 32'(bus.cpu_stall), 0);
    check("t1_c2_ce_n", 32'(bus.sram_ce_n), 1);
    bus.cpu_req = 1'b0;

    // Host write 0x1234 to 0x20, then CPU read-back
    @(negedge clk);
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_adr = 8'h20; bus.host_wdata = 16'h1234;
    sb.push_back(mk(1'b1, 1'b0, 16'h0000));
    #1;
    check("t2_c0_gnt", 32'(bus.host_gnt), 1);
    @(negedge clk);
    bus.host_req = 1'b0;
    check("t2_c1_strobes", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dout_en}), 32'b0111);
    check("t2_c1_adr", 32'(bus.sram_adr), 32'h20);
    check("t2_c1_dout", 32'(bus.sram_dout), 32'h1234);
    check("t2_c1_gnt", 32'(bus.host_gnt), 0);
    @(negedge clk);
    check("t2_c2_strobes", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dout_en}), 32'b0101);
    check("t2_c2_dout", 32'(bus.sram_dout), 32'h1234);
    check("t2_c2_done", 32'(bus.host_done), 0);
    @(negedge clk);
    check("t2_c3_done", 32'(bus.host_done), 1);
    check("t2_c3_strobes", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dout_en}), 32'b1110);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 8'h20;
    sb.push_back(mk(1'b0, 1'b1, 16'h1234));
    @(negedge clk);
    @(negedge clk);
    check("t2_rb_done", 32'(bus.cpu_done), 1);
    check("t2_rb_rdata", 32'(bus.rdata), 32'h1234);
    bus.cpu_req = 1'b0;

    // Host read with request dropped after acceptance
    @(negedge clk);
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_adr = 8'h05;
    sb.push_back(mk(1'b1, 1'b1, 16'h002D));
    #1;
    check("t3_c0_gnt", 32'(bus.host_gnt), 1);
    @(negedge clk);
    bus.host_req = 1'b0;
    check("t3_c1_oe_n", 32'(bus.sram_oe_n), 0);
    @(negedge clk);
    check("t3_c2_done", 32'(bus.host_done), 1);
    check("t3_c2_rdata", 32'(bus.rdata), 32'h002D);
    check("t3_c2_gnt", 32'(bus.host_gnt), 0);

    // Both requesting continuously: host burst of 4, then CPU
    @(negedge clk);
    bus.cpu_req = 1'b1;  bus.cpu_we = 1'b0;  bus.cpu_adr = 8'h05;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_adr = 8'h20;
    for (int r = 0; r < 2; r++) begin
      for (int h = 0; h < 4; h++) sb.push_back(mk(1'b1, 1'b1, 16'h1234));
      sb.push_back(mk(1'b0, 1'b1, 16'h002D));
    end
    dones = 0;
    cyc   = 0;
    while (dones < 10 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.cpu_done || bus.host_done) dones++;
    end
    bus.cpu_req = 1'b0; bus.host_req = 1'b0;
    check("t4_dones", 32'(dones), 10);
    check("t4_cycles", 32'(cyc), 20);

    // Reset during WR_PULSE drops the write
    @(negedge clk);
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_adr = 8'h30; bus.host_wdata = 16'hBEEF;
    @(negedge clk);
    bus.host_req = 1'b0;
    @(negedge clk);
    check("t5_pulse_we_n", 32'(bus.sram_we_n), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_rst_strobes", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dout_en}), 32'b1110);
    check("t5_rst_done", 32'(bus.host_done), 0);
    check("t5_rst_rdata", 32'(bus.rdata), 0);
    check("t5_rst_adr", 32'(bus.sram_adr), 0);
    @(negedge clk);
    check("t5_post_done", 32'(bus.host_done), 0);
    check("t5_post_ce_n", 32'(bus.sram_ce_n), 1);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 8'h05;
    sb.push_back(mk(1'b0, 1'b1, 16'h002D));
    @(negedge clk);
    check("t5_idle_rd_oe_n", 32'(bus.sram_oe_n), 0);
    @(negedge clk);
    check("t5_idle_rd_done", 32'(bus.cpu_done), 1);
    bus.cpu_req = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, SRAM address width.
REQ-002 Parameter DATA_W, default 16, SRAM data width.
REQ-003 Parameter HOST_BURST_MAX, default 4, maximum consecutive host grants while the CPU waits.
REQ-004 clk  input  1  single-phase board clock for the arbiter and SRAM strobes.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 cpu_req / cpu_we  input  1 / 1  CPU access request; 1 = write.
REQ-007 cpu_adr / cpu_wdata  input  ADDR_W / DATA_W  CPU address and write data.
REQ-008 cpu_stall  output  1  holds the processor clocks while its access is pending.
REQ-009 cpu_done  output  1  one-cycle pulse when the CPU access completes.
REQ-010 host_req / host_we / host_adr / host_wdata  input  1 / 1 / ADDR_W / DATA_W  loader or debug port request, same meaning as the CPU signals.
REQ-011 host_gnt / host_done  output  1 / 1  one-cycle acceptance pulse and one-cycle completion pulse.
REQ-012 rdata  output  DATA_W  read data register, valid for the owner when its done pulse is high after a read.
REQ-013 sram_ce_n / sram_oe_n / sram_we_n  output  1 each  SRAM strobes, active-low.
REQ-014 sram_adr / sram_dout / sram_dout_en  output  ADDR_W / DATA_W / 1  SRAM address, write data, and board tristate enable.
REQ-015 sram_din  input  DATA_W  SRAM read data.

Function
REQ-016 The arbiter SHALL use four states: IDLE, RD, WR_SETUP, WR_PULSE.
REQ-017 In IDLE with any request, the arbiter SHALL latch the winner's owner, we, adr and wdata, and go to RD (we=0) or WR_SETUP (we=1) on the next edge.
REQ-018 Arbitration SHALL give the host fixed priority, except that the CPU SHALL win whenever host_streak equals HOST_BURST_MAX and cpu_req=1.
REQ-019 host_streak SHALL increment on each host grant made while cpu_req=1, SHALL saturate at HOST_BURST_MAX, and SHALL clear on a CPU grant or on any arbitration with cpu_req=0.
REQ-020 host_gnt SHALL pulse for exactly one cycle, in the accepting cycle.
REQ-021 Read: RD SHALL last one cycle with ce_n=0, oe_n=0, we_n=1.
REQ-022 Read: at the end of RD, rdata SHALL capture sram_din, and the owner's done pulse SHALL occur in the following cycle with the arbiter back in IDLE (read latency 2 cycles from acceptance).
REQ-023 Write: WR_SETUP SHALL drive ce_n=0, oe_n=1, we_n=1, dout_en=1.
REQ-024 Write: WR_PULSE SHALL drive we_n=0 with adr, dout and dout_en=1 held.
REQ-025 Write: the done pulse SHALL occur in the next IDLE cycle, with dout_en=0 in that cycle (write latency 3 cycles).
REQ-026 sram_oe_n=0 and sram_we_n=0 SHALL never coincide.
REQ-027 sram_dout_en=1 SHALL never coincide with sram_oe_n=0.
REQ-028 All SRAM strobes, address and data outputs SHALL be registered.
REQ-029 The IDLE cycle carrying a done pulse SHALL also arbitrate, so back-to-back reads sustain one access per 2 cycles.
REQ-030 cpu_stall SHALL equal cpu_req & ~cpu_done.
REQ-031 Deasserting a request after acceptance SHALL NOT abort the access; its done pulse still occurs.
REQ-032 Simultaneous cpu_req and host_req in IDLE SHALL resolve per REQ-018 in the same cycle; the loser SHALL wait with no grant.
REQ-033 Outside an access, rdata SHALL hold its last value.

Reset
REQ-034 On reset the arbiter SHALL enter IDLE and clear host_streak, host_gnt, host_done, cpu_done and rdata (to 0).
REQ-035 On reset the SRAM outputs SHALL be ce_n=oe_n=we_n=1, dout_en=0, adr=0, dout=0.
REQ-036 Reset mid-access SHALL drop the transaction with no done pulse, and strobes SHALL be inactive in the first cycle after the reset edge.

Structure
REQ-037 Package sram_arb_pkg SHALL hold the state enum, the owner enum (OWN_CPU, OWN_HOST), and the ADDR_W/DATA_W defaults.
REQ-038 The priority select and host_streak counter SHALL be one sub-module, sram_arb_sel; the FSM and strobe registers SHALL remain in sram_arbiter.

Verification
REQ-039 CPU read of adr 0x05 holding 0x002D, no host activity -> strobes low in cycle 1; cpu_done=1 with rdata=0x002D in cycle 2; cpu_stall=1 in cycles 0-1.
REQ-040 Host write adr 0x20 data 0x1234 -> WR_SETUP then WR_PULSE with we_n low exactly one cycle; host_done in cycle 3; a CPU read-back of 0x20 returns 0x1234.
REQ-041 cpu_req and host_req held high continuously, HOST_BURST_MAX=4 -> grant order H,H,H,H,C,H,H,H,H,C.
REQ-042 Reset asserted during WR_PULSE -> next cycle strobes inactive and dout_en=0; no host_done; state IDLE.
REQ-043 Host read accepted then host_req dropped in cycle 1 -> access completes; host_done=1 in cycle 2.
REQ-044 Every scenario SHALL be checked by assertions for REQ-026 and REQ-027.
